// File: rtl/mux2_arb_pkg.sv
// Shared definitions for the round-robin 2:1 mux arbiter slice.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  localparam int unsigned DEF_WIDTH    = 64;
  localparam int unsigned DEF_MAX_HOLD = 4;

endpackage

// File: rtl/mux2_w.sv
// Combinational WIDTH-bit 2:1 mux: selector=1 picks y, selector=0 picks x.
module mux2_w #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             selector,
  output logic [WIDTH-1:0] o
);

  always_comb begin
    o = selector ? y : x;
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter owning the 2:1 mux selector, with bounded bursts
// and a registered valid/ready output stage.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             o_ready,
  output logic             ack0,
  output logic             ack1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             selector,
  output logic [WIDTH-1:0] o,
  output logic             o_valid
);

  localparam int unsigned   CW   = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_HOLD);

  state_t            state, state_n;
  logic [CW-1:0]     count, count_n, cnt_after;
  logic              last, last_n;
  logic              beat;
  logic [WIDTH-1:0]  mux_o;

  assign gnt0     = (state == GRANT0);
  assign gnt1     = (state == GRANT1);
  assign selector = gnt1;
  assign ack0     = gnt0 && req0 && o_ready;
  assign ack1     = gnt1 && req1 && o_ready;
  assign beat     = ack0 || ack1;

  mux2_w #(.WIDTH(WIDTH)) u_mux (
    .x        (d0),
    .y        (d1),
    .selector (selector),
    .o        (mux_o)
  );

  // cnt_after is the count as it stands once this edge's beat (if any) lands;
  // testing it against MAXC covers both the beat that fills the burst and a
  // late-arriving competitor after saturation.
  always_comb begin
    cnt_after = count;
    if (beat && (count != MAXC)) cnt_after = count + CW'(1);
  end

  always_comb begin
    state_n = state;
    count_n = cnt_after;
    last_n  = last;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_n = last ? GRANT0 : GRANT1;
        else if (req0)     state_n = GRANT0;
        else if (req1)     state_n = GRANT1;
      end
      GRANT0: begin
        if (!req0)                          state_n = req1 ? GRANT1 : IDLE;
        else if ((cnt_after == MAXC) && req1) state_n = GRANT1;
      end
      GRANT1: begin
        if (!req1)                          state_n = req0 ? GRANT0 : IDLE;
        else if ((cnt_after == MAXC) && req0) state_n = GRANT0;
      end
      default: state_n = IDLE;
    endcase
    if ((state_n != state) && (state_n != IDLE)) begin
      count_n = '0;
      last_n  = (state_n == GRANT1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      last    <= 1'b1;
      o       <= '0;
      o_valid <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      last    <= last_n;
      o_valid <= beat;
      if (beat) o <= mux_o;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed, table-driven bench for mux2_rr_arbiter (WIDTH=64, MAX_HOLD=4).
module tb_mux2_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset, req0, req1, o_ready;
  logic [63:0] d0, d1;
  logic        ack0, ack1, gnt0, gnt1, selector, o_valid;
  logic [63:0] o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.WIDTH(64), .MAX_HOLD(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .d0       (d0),
    .d1       (d1),
    .o_ready  (o_ready),
    .ack0     (ack0),
    .ack1     (ack1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .selector (selector),
    .o        (o),
    .o_valid  (o_valid)
  );

  typedef struct {
    logic        rst, r0, r1, rdy;
    logic [63:0] v0, v1;
    logic [1:0]  eack;   // {ack1, ack0} before the edge
    logic [1:0]  egnt;   // {gnt1, gnt0} after the edge
    logic        eov;
    logic [63:0] eo;
  } vec_t;

  localparam logic [63:0] A = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] B = 64'h1111_2222_3333_4444;
  localparam logic [63:0] C = 64'hC0DE_0000_0000_0001;
  localparam logic [63:0] E = 64'hEEEE_0000_0000_0000;

  vec_t vt[25];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic post_chk(input string nm, input logic [1:0] egnt, input logic eov,
                          input logic [63:0] eo);
    chk({nm, " gnt/sel"}, {61'd0, selector, gnt1, gnt0}, {61'd0, egnt[1], egnt});
    chk({nm, " o_valid"}, {63'd0, o_valid}, {63'd0, eov});
    chk({nm, " o"}, o, eo);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; o_ready = 1'b1; d0 = '0; d1 = '0;
    @(posedge clk); #1;
    post_chk("reset", 2'b00, 1'b0, 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_o;
    int unsigned owner, nxt;

    //            rst r0 r1 rdy v0 v1 eack   egnt   eov eo
    vt[0]  = '{1'b0,1'b1,1'b0,1'b1, A, B, 2'b00, 2'b01, 1'b0, 64'd0};
    vt[1]  = '{1'b0,1'b1,1'b0,1'b1, A, B, 2'b01, 2'b01, 1'b1, A};
    vt[2]  = '{1'b0,1'b1,1'b0,1'b1, C, B, 2'b01, 2'b01, 1'b1, C};
    vt[3]  = '{1'b0,1'b0,1'b0,1'b1, C, B, 2'b00, 2'b00, 1'b0, C};
    vt[4]  = '{1'b0,1'b0,1'b1,1'b1, C, B, 2'b00, 2'b10, 1'b0, C};
    vt[5]  = '{1'b0,1'b0,1'b1,1'b1, C, B, 2'b10, 2'b10, 1'b1, B};
    vt[6]  = '{1'b0,1'b0,1'b0,1'b1, C, B, 2'b00, 2'b00, 1'b0, B};
    vt[7]  = '{1'b0,1'b1,1'b0,1'b1, A, B, 2'b00, 2'b01, 1'b0, B};
    vt[8]  = '{1'b0,1'b1,1'b0,1'b1, A, B, 2'b01, 2'b01, 1'b1, A};
    vt[9]  = '{1'b0,1'b0,1'b0,1'b1, A, B, 2'b00, 2'b00, 1'b0, A};
    vt[10] = '{1'b0,1'b1,1'b1,1'b1, C, B, 2'b00, 2'b10, 1'b0, A};
    vt[11] = '{1'b0,1'b1,1'b1,1'b1, C, B, 2'b10, 2'b10, 1'b1, B};
    vt[12] = '{1'b0,1'b0,1'b0,1'b1, C, B, 2'b00, 2'b00, 1'b0, B};
    vt[13] = '{1'b0,1'b1,1'b0,1'b1, A, B, 2'b00, 2'b01, 1'b0, B};
    vt[14] = '{1'b0,1'b1,1'b0,1'b1, A, B, 2'b01, 2'b01, 1'b1, A};
    vt[15] = '{1'b0,1'b1,1'b1,1'b0, C, B, 2'b00, 2'b01, 1'b0, A};
    vt[16] = '{1'b0,1'b1,1'b1,1'b0, C, B, 2'b00, 2'b01, 1'b0, A};
    vt[17] = '{1'b0,1'b1,1'b1,1'b0, C, B, 2'b00, 2'b01, 1'b0, A};
    vt[18] = '{1'b0,1'b1,1'b1,1'b1, C, B, 2'b01, 2'b01, 1'b1, C};
    vt[19] = '{1'b0,1'b1,1'b1,1'b1, A, B, 2'b01, 2'b01, 1'b1, A};
    vt[20] = '{1'b0,1'b1,1'b1,1'b1, C, B, 2'b01, 2'b10, 1'b1, C};
    vt[21] = '{1'b0,1'b1,1'b1,1'b1, C, B, 2'b10, 2'b10, 1'b1, B};
    vt[22] = '{1'b1,1'b1,1'b1,1'b1, C, B, 2'b10, 2'b00, 1'b0, 64'd0};
    vt[23] = '{1'b0,1'b1,1'b1,1'b1, C, B, 2'b00, 2'b01, 1'b0, 64'd0};
    vt[24] = '{1'b0,1'b1,1'b1,1'b1, C, B, 2'b01, 2'b01, 1'b1, C};

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; o_ready = 1'b1; d0 = '0; d1 = '0;
    do_reset();

    for (int i = 0; i < 25; i++) begin
      reset = vt[i].rst; req0 = vt[i].r0; req1 = vt[i].r1;
      o_ready = vt[i].rdy; d0 = vt[i].v0; d1 = vt[i].v1;
      #1;
      chk($sformatf("vec%0d ack", i), {62'd0, ack1, ack0}, {62'd0, vt[i].eack});
      @(posedge clk); #1;
      post_chk($sformatf("vec%0d", i), vt[i].egnt, vt[i].eov, vt[i].eo);
      @(negedge clk);
    end

    // Both requesting from reset: alternating 4-beat bursts, no valid gap.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; o_ready = 1'b1;
    d0 = 64'h00D0_0000_0000_0000; d1 = 64'h00D1_0000_0000_0000;
    @(posedge clk); #1;
    post_chk("rr first grant", 2'b01, 1'b0, 64'd0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      owner = (k / 4) % 2;
      nxt   = ((k + 1) / 4) % 2;
      chk($sformatf("rr beat%0d ack", k), {62'd0, ack1, ack0},
          (owner == 1) ? 64'd2 : 64'd1);
      exp_o = (owner == 1) ? d1 : d0;
      @(posedge clk); #1;
      post_chk($sformatf("rr beat%0d", k), (nxt == 1) ? 2'b10 : 2'b01, 1'b1, exp_o);
      if (owner == 1) d1 = d1 + 64'd1;
      else            d0 = d0 + 64'd1;
    end

    // Saturated burst with no competitor stays put; a late competitor switches.
    do_reset();
    req0 = 1'b1; req1 = 1'b0; o_ready = 1'b1; d0 = E;
    @(posedge clk); #1;
    post_chk("sat grant", 2'b01, 1'b0, 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      d0 = E + 64'(k);
      @(posedge clk); #1;
      post_chk($sformatf("sat beat%0d", k), 2'b01, 1'b1, E + 64'(k));
    end
    @(negedge clk);
    req1 = 1'b1; d1 = B; d0 = C;
    @(posedge clk); #1;
    post_chk("late switch", 2'b10, 1'b1, C);
    @(negedge clk); #1;
    chk("late switch ack", {62'd0, ack1, ack0}, 64'd2);
    @(posedge clk); #1;
    post_chk("late switch beat", 2'b10, 1'b1, B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
